// File: rtl/arm_imm_encoder_pkg.sv
// Shared definitions for the immediate encoder and the operand-2 shifter.
package arm_imm_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ROT_W  = 4;
   localparam int unsigned IMM_W  = 8;

   // Operand-2 shifter mode that decodes {rot, imm8} as imm8 ror (2*rot)
   localparam logic [1:0] SHIFTER_MODE_IMM = 2'b00;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SEARCH = 2'b01,
      DONE   = 2'b10
   } state_t;

endpackage

// File: rtl/arm_imm_encoder_imm_rot_check.sv
// Combinational check: does operand, rotated left by 2*rot, fit in imm8?
// Rotating left by 2*rot is the inverse of the shifter's ror by 2*rot.
module imm_rot_check
   import arm_imm_pkg::*;
(
   input  logic [DATA_W-1:0] operand,
   input  logic [ROT_W-1:0]  rot,
   output logic              fit,
   output logic [IMM_W-1:0]  imm8
);

   logic [5:0]        sh;
   logic [DATA_W-1:0] cand;

   // Rotate left by 2*rot; a shift by 32 yields 0, so rot=0 passes operand through
   always_comb begin
      sh   = {1'b0, rot, 1'b0};
      cand = (operand << sh) | (operand >> (6'd32 - sh));
      fit  = (cand[DATA_W-1:IMM_W] == '0);
      imm8 = cand[IMM_W-1:0];
   end

endmodule

// File: rtl/arm_imm_encoder.sv
// Multi-cycle encoder for the rotated-immediate operand format.
// Optional macro INV_SEARCH_EN adds a second search pass on ~value (MVN form).
module arm_imm_encoder
   import arm_imm_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [DATA_W-1:0]        value,
   output logic                     busy,
   output logic                     done,
   output logic                     valid,
   output logic [ROT_W+IMM_W-1:0]   L,
   output logic                     inverted
);

   state_t            state;
   logic [ROT_W-1:0]  rot_cnt;
   logic [DATA_W-1:0] value_q;
   logic [DATA_W-1:0] operand;
   logic              fit;
   logic [IMM_W-1:0]  imm8;

`ifdef INV_SEARCH_EN
   logic pass;
   logic inv_q;

   // Pass 1 searches the complement of the latched constant
   always_comb begin
      operand = pass ? ~value_q : value_q;
   end

   assign inverted = inv_q;
`else
   // Single pass: the search always runs on the latched constant
   always_comb begin
      operand = value_q;
   end

   assign inverted = 1'b0;
`endif

   imm_rot_check u_check (
      .operand (operand),
      .rot     (rot_cnt),
      .fit     (fit),
      .imm8    (imm8)
   );

   // Search FSM: one rotation per cycle, lowest rotation wins
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         rot_cnt <= '0;
         value_q <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         valid   <= 1'b0;
         L       <= '0;
`ifdef INV_SEARCH_EN
         pass    <= 1'b0;
         inv_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  value_q <= value;
                  rot_cnt <= '0;
                  busy    <= 1'b1;
                  valid   <= 1'b0;
                  L       <= '0;
`ifdef INV_SEARCH_EN
                  pass    <= 1'b0;
                  inv_q   <= 1'b0;
`endif
                  state   <= SEARCH;
               end
            end
            SEARCH: begin
               if (fit) begin
                  L     <= {rot_cnt, imm8};
                  valid <= 1'b1;
`ifdef INV_SEARCH_EN
                  inv_q <= pass;
`endif
                  busy  <= 1'b0;
                  state <= DONE;
               end else if (rot_cnt == '1) begin
                  rot_cnt <= '0;
`ifdef INV_SEARCH_EN
                  if (!pass) begin
                     pass <= 1'b1;
                  end else begin
                     busy  <= 1'b0;
                     state <= DONE;
                  end
`else
                  busy  <= 1'b0;
                  state <= DONE;
`endif
               end else begin
                  rot_cnt <= rot_cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Scoreboard bench for arm_imm_encoder: directed constants with hand-computed
// encodings and latencies; honours INV_SEARCH_EN when defined.
module tb_arm_imm_encoder;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] value;
   logic        busy;
   logic        done;
   logic        valid;
   logic [11:0] L;
   logic        inverted;

   arm_imm_encoder dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .value    (value),
      .busy     (busy),
      .done     (done),
      .valid    (valid),
      .L        (L),
      .inverted (inverted)
   );

   typedef struct {
      logic [31:0] val;
      logic        exp_valid;
      logic [11:0] exp_L;
      logic        exp_inv;
      int          exp_lat;
      int          k;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Shifter immediate decode: imm8 ror (2*rot)
   function automatic logic [31:0] shifter_imm(input logic [11:0] op);
      logic [31:0] v;
      int          s;
      v = {24'b0, op[7:0]};
      s = 2 * int'(op[11:8]);
      return (v >> s) | (v << (32 - s));
   endfunction

   // Monitor: pop and compare on every done pulse
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, want no result", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("valid[%h]", e.val), {31'b0, valid}, {31'b0, e.exp_valid});
            check($sformatf("L[%h]", e.val), {20'b0, L}, {20'b0, e.exp_L});
            check($sformatf("inverted[%h]", e.val), {31'b0, inverted}, {31'b0, e.exp_inv});
            check($sformatf("latency[%h]", e.val), 32'(cyc - e.k), 32'(e.exp_lat));
            if (valid === 1'b1)
               check($sformatf("decode[%h]", e.val), shifter_imm(L),
                     inverted ? ~e.val : e.val);
         end
      end
   end

   task automatic issue(input logic [31:0] v, input logic ev, input logic [11:0] el,
                        input logic ei, input int lat, input bit push);
      exp_t e;
      @(negedge clk);
      value = v;
      start = 1'b1;
      e.val = v; e.exp_valid = ev; e.exp_L = el; e.exp_inv = ei;
      e.exp_lat = lat; e.k = cyc + 1;
      if (push) sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_result();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: got no done within 100 cycles, want %0d pending result(s)", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [31:0] v, input logic ev, input logic [11:0] el,
                      input logic ei, input int lat);
      issue(v, ev, el, ei, lat, 1'b1);
      wait_result();
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      value = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_valid", {31'b0, valid}, 32'd0);
      check("reset_L", {20'b0, L}, 32'd0);
      check("reset_inverted", {31'b0, inverted}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run(32'h0000_00FF, 1'b1, 12'h0FF, 1'b0, 2);
      run(32'hFF00_0000, 1'b1, 12'h4FF, 1'b0, 6);
      run(32'h0000_0104, 1'b1, 12'hF41, 1'b0, 17);
      run(32'h0000_0000, 1'b1, 12'h000, 1'b0, 2);
      run(32'h8000_0001, 1'b1, 12'h106, 1'b0, 3);
      run(32'hF000_000F, 1'b1, 12'h2FF, 1'b0, 4);
      run(32'h0003_FC00, 1'b1, 12'hBFF, 1'b0, 13);
`ifdef INV_SEARCH_EN
      run(32'h0000_0101, 1'b0, 12'h000, 1'b0, 33);
      run(32'hFFFF_FF00, 1'b1, 12'h0FF, 1'b1, 18);
`else
      run(32'h0000_0101, 1'b0, 12'h000, 1'b0, 17);
      run(32'hFFFF_FF00, 1'b0, 12'h000, 1'b0, 17);
`endif

      // start pulses while busy must not disturb the running search
      issue(32'h0000_0104, 1'b1, 12'hF41, 1'b0, 17, 1'b1);
      repeat (3) @(negedge clk);
      value = 32'h0000_00FF;
      start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      wait_result();

      // reset during SEARCH cycle 5 aborts without a done pulse
      issue(32'h0000_0104, 1'b1, 12'hF41, 1'b0, 17, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_valid", {31'b0, valid}, 32'd0);
      check("abort_L", {20'b0, L}, 32'd0);
      check("abort_inverted", {31'b0, inverted}, 32'd0);
      reset = 1'b1;
      repeat (20) @(negedge clk);

      run(32'h0000_00FF, 1'b1, 12'h0FF, 1'b0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of run by 1 ms, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
